uart_ctrl_p: RTL and testbench

Parametrised UART controller. Successor to the fixed-format uart0: runtime-programmable baud rate, frame format (5–8 data bits, none/even/odd parity, 1/2 stop bits), parametrised TX and RX FIFOs, and per-byte error reporting. Sits on the CPU peripheral bus behind the memory-mapped register decoder; serial pins go to the board.

---
 rtl/uart_ctrl_p_if.sv | 27 ++
 rtl/uart_ctrl_p.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_ctrl_p.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_p_if.sv
// CPU-side bus bundle for uart_ctrl_p: TX push, RX pop/status and error clear.
interface uart_ctrl_p_if #(
  parameter int RX_DEPTH_LOG2 = 4
);
  logic [7:0]             tx_data;
  logic                   tx_wr;
  logic                   tx_full;
  logic                   tx_busy;
  logic [7:0]             rx_data;
  logic                   rx_frame_err;
  logic                   rx_par_err;
  logic                   rx_rd;
  logic                   rx_empty;
  logic [RX_DEPTH_LOG2:0] rx_level;
  logic                   rx_ovf;
  logic                   err_clr;

  modport master (
    output tx_data, tx_wr, rx_rd, err_clr,
    input  tx_full, tx_busy, rx_data, rx_frame_err, rx_par_err, rx_empty, rx_level, rx_ovf
  );

  modport slave (
    input  tx_data, tx_wr, rx_rd, err_clr,
    output tx_full, tx_busy, rx_data, rx_frame_err, rx_par_err, rx_empty, rx_level, rx_ovf
  );
endinterface

// File: rtl/uart_ctrl_p.sv
// Parametrised UART: programmable divisor and frame format, TX/RX FIFOs,
// per-entry frame/parity error flags and sticky RX overflow.
module uart_ctrl_p #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int DIV_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  uart_ctrl_p_if.slave     bus,
  input  logic             ser_rxd,
  output logic             ser_txd
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]             tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [TX_DEPTH_LOG2:0] tx_cnt;
  logic                   tx_empty, tx_push, tx_pop;
  logic [7:0]             tx_head, tx_mask;

  assign tx_empty    = (tx_cnt == '0);
  assign bus.tx_full = (tx_cnt == (TX_DEPTH_LOG2+1)'(TX_DEPTH));
  assign tx_push     = bus.tx_wr && (!bus.tx_full || tx_pop);
  assign tx_head     = tx_mem[tx_rp];
  assign tx_mask     = 8'hFF >> (2'd3 - data_bits);

  // TX FIFO storage
  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp] <= bus.tx_data;

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end

  // ---------------- TX shifter ----------------
  tx_state_t        tx_state, tx_nxt;
  logic [DIV_W-1:0] tx_div_q, tx_pre;
  logic [3:0]       tx_tcnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shreg;
  logic [1:0]       tx_db;
  logic             tx_par, tx_pen, tx_stop2_q, txd_nxt, tx_done;
  logic             tx_tick, tx_bit_end, tx_last;

  assign tx_tick     = (tx_pre == tx_div_q);
  assign tx_bit_end  = tx_tick && (tx_tcnt == 4'd15);
  assign tx_last     = (tx_idx == 3'd4 + {1'b0, tx_db});
  assign bus.tx_busy = !tx_empty || (tx_state != TX_IDLE);

  // TX state register and line driver; ser_txd follows the state one clock later
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_state <= TX_IDLE;
      ser_txd  <= 1'b1;
    end else begin
      tx_state <= tx_nxt;
      ser_txd  <= txd_nxt;
    end

  // TX next state, line level and FIFO pop (frames chain with no idle gap)
  always_comb begin
    tx_nxt  = tx_state;
    tx_pop  = 1'b0;
    txd_nxt = 1'b1;
    tx_done = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_nxt = TX_START;
        tx_pop = 1'b1;
      end
      TX_START: begin
        txd_nxt = 1'b0;
        if (tx_bit_end) tx_nxt = TX_DATA;
      end
      TX_DATA: begin
        txd_nxt = tx_shreg[tx_idx];
        if (tx_bit_end && tx_last) tx_nxt = tx_pen ? TX_PARITY : TX_STOP1;
      end
      TX_PARITY: begin
        txd_nxt = tx_par;
        if (tx_bit_end) tx_nxt = TX_STOP1;
      end
      TX_STOP1: if (tx_bit_end) begin
        if (tx_stop2_q) tx_nxt = TX_STOP2;
        else            tx_done = 1'b1;
      end
      TX_STOP2: if (tx_bit_end) tx_done = 1'b1;
      default: tx_nxt = TX_IDLE;
    endcase
    if (tx_done) begin
      if (!tx_empty) begin
        tx_nxt = TX_START;
        tx_pop = 1'b1;
      end else begin
        tx_nxt = TX_IDLE;
      end
    end
  end

  // TX datapath: latch byte/config at frame start, run prescaler and bit counters
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_div_q   <= '0;
      tx_pre     <= '0;
      tx_tcnt    <= '0;
      tx_idx     <= '0;
      tx_shreg   <= '0;
      tx_par     <= 1'b0;
      tx_db      <= '0;
      tx_pen     <= 1'b0;
      tx_stop2_q <= 1'b0;
    end else if (tx_pop) begin
      tx_div_q   <= baud_div;
      tx_pre     <= '0;
      tx_tcnt    <= '0;
      tx_idx     <= '0;
      tx_shreg   <= tx_head & tx_mask;
      tx_par     <= (^(tx_head & tx_mask)) ^ parity_odd;
      tx_db      <= data_bits;
      tx_pen     <= parity_en;
      tx_stop2_q <= stop2;
    end else if (tx_state != TX_IDLE) begin
      tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
      if (tx_tick) tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_bit_end && tx_state == TX_DATA) tx_idx <= tx_idx + 1'b1;
    end

  // ---------------- RX FIFO ----------------
  logic [9:0]               rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [RX_DEPTH_LOG2:0]   rx_cnt;
  logic                     rx_empty, rx_full, rx_push, rx_pop, rx_wr;
  logic [9:0]               rx_entry, rx_head;

  assign rx_empty         = (rx_cnt == '0);
  assign rx_full          = (rx_cnt == (RX_DEPTH_LOG2+1)'(RX_DEPTH));
  assign rx_pop           = bus.rx_rd && !rx_empty;
  assign rx_wr            = rx_push && (!rx_full || rx_pop);
  assign rx_head          = rx_mem[rx_rp];
  assign bus.rx_empty     = rx_empty;
  assign bus.rx_level     = rx_cnt;
  assign bus.rx_data      = rx_empty ? '0 : rx_head[7:0];
  assign bus.rx_par_err   = !rx_empty && rx_head[8];
  assign bus.rx_frame_err = !rx_empty && rx_head[9];

  // RX FIFO storage
  always_ff @(posedge clk)
    if (rx_wr) rx_mem[rx_wp] <= rx_entry;

  // RX FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      bus.rx_ovf <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      case ({rx_wr, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_push && !rx_wr) bus.rx_ovf <= 1'b1;
      else if (bus.err_clr)  bus.rx_ovf <= 1'b0;
    end

  // ---------------- RX deserialiser ----------------
  rx_state_t        rx_state, rx_nxt;
  logic             s1, s2, s3;
  logic [DIV_W-1:0] rx_div_q, rx_pre;
  logic [3:0]       rx_tcnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shreg;
  logic [1:0]       rx_db;
  logic             rx_pbit, rx_pen, rx_podd, rx_start;
  logic             rx_tick, rx_mid, rx_bit_end, rx_last;

  assign rx_tick    = (rx_pre == rx_div_q);
  assign rx_mid     = rx_tick && (rx_tcnt == 4'd7);
  assign rx_bit_end = rx_tick && (rx_tcnt == 4'd15);
  assign rx_last    = (rx_idx == 3'd4 + {1'b0, rx_db});
  assign rx_entry   = {!s2, rx_pen && (rx_pbit != ((^rx_shreg) ^ rx_podd)), rx_shreg};

  // RX synchroniser (s3 holds the previous synced level for edge detect) and state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      s1       <= ser_rxd;
      s2       <= s1;
      s3       <= s2;
      rx_state <= rx_nxt;
    end

  // RX next state; stop is sampled mid-bit and the FSM re-arms straight away
  always_comb begin
    rx_nxt   = rx_state;
    rx_start = 1'b0;
    rx_push  = 1'b0;
    case (rx_state)
      RX_IDLE: if (s3 && !s2) begin
        rx_nxt   = RX_START;
        rx_start = 1'b1;
      end
      RX_START: begin
        if (rx_mid && s2)    rx_nxt = RX_IDLE;
        else if (rx_bit_end) rx_nxt = RX_DATA;
      end
      RX_DATA: if (rx_bit_end && rx_last) rx_nxt = rx_pen ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_end) rx_nxt = RX_STOP;
      RX_STOP: if (rx_mid) begin
        rx_push = 1'b1;
        rx_nxt  = RX_IDLE;
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  // RX datapath: latch config at start detect, sample data/parity mid-bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_div_q <= '0;
      rx_pre   <= '0;
      rx_tcnt  <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
      rx_pbit  <= 1'b0;
      rx_db    <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
    end else if (rx_start) begin
      rx_div_q <= baud_div;
      rx_pre   <= '0;
      rx_tcnt  <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
      rx_db    <= data_bits;
      rx_pen   <= parity_en;
      rx_podd  <= parity_odd;
    end else if (rx_state != RX_IDLE) begin
      rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
      if (rx_tick) rx_tcnt <= rx_tcnt + 1'b1;
      if (rx_mid && rx_state == RX_DATA) rx_shreg[rx_idx] <= s2;
      if (rx_bit_end && rx_state == RX_DATA) rx_idx <= rx_idx + 1'b1;
      if (rx_mid && rx_state == RX_PARITY) rx_pbit <= s2;
    end
endmodule

// File: tb/tb_uart_ctrl_p.sv
// Directed bench for uart_ctrl_p: TX waveform, loopback, RX errors,
// overflow, glitch rejection, TX FIFO full and mid-frame reset.
module tb_uart_ctrl_p;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic        ser_rxd, ser_txd;
  logic        rxd_drv = 1'b1, loopback = 1'b0;

  int checks = 0;
  int failures = 0;

  uart_ctrl_p_if #(.RX_DEPTH_LOG2(2)) bus ();

  assign ser_rxd = loopback ? ser_txd : rxd_drv;

  uart_ctrl_p #(.TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .bus(bus), .ser_rxd(ser_rxd), .ser_txd(ser_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    bus.rx_rd = 1'b1;
    wait_clk(1);
    bus.rx_rd = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    check({tag, "_data"}, bus.rx_data, d);
    check({tag, "_fe"}, bus.rx_frame_err, fe);
    check({tag, "_pe"}, bus.rx_par_err, pe);
  endtask

  // Drives one frame on rxd_drv, followed by two idle bit times.
  task automatic send_frame(input logic [7:0] b, input int nb, input logic pen, input logic podd,
                            input logic par_flip, input logic stopv, input int bclk);
    logic p;
    p = podd ^ par_flip;
    rxd_drv = 1'b0;
    wait_clk(bclk);
    for (int i = 0; i < nb; i++) begin
      rxd_drv = b[i];
      p = p ^ b[i];
      wait_clk(bclk);
    end
    if (pen) begin
      rxd_drv = p;
      wait_clk(bclk);
    end
    rxd_drv = stopv;
    wait_clk(bclk);
    rxd_drv = 1'b1;
    wait_clk(2 * bclk);
  endtask

  initial begin
    logic [7:0] b;
    int peak;
    logic got3;

    bus.tx_data = '0;
    bus.tx_wr   = 1'b0;
    bus.rx_rd   = 1'b0;
    bus.err_clr = 1'b0;

    // reset state
    wait_clk(3);
    check("rst_txd", ser_txd, 1);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_tx_busy", bus.tx_busy, 0);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_rx_level", bus.rx_level, 0);
    check_head("rst_head", 8'h00, 1'b0, 1'b0);
    check("rst_ovf", bus.rx_ovf, 0);
    rst = 1'b1;
    wait_clk(2);

    // T1: 8N1, div 0, 0xA5 waveform
    baud_div = 16'd0; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    b = 8'hA5;
    bus.tx_data = b;
    bus.tx_wr = 1'b1;
    wait_clk(1);
    bus.tx_wr = 1'b0;
    check("t1_txd_w1", ser_txd, 1);
    wait_clk(1);
    check("t1_txd_w2", ser_txd, 1);
    wait_clk(1);
    check("t1_start_edge", ser_txd, 0);
    wait_clk(8);
    check("t1_start_mid", ser_txd, 0);
    for (int i = 0; i < 8; i++) begin
      wait_clk(16);
      check("t1_bit", ser_txd, b[i]);
    end
    wait_clk(16);
    check("t1_stop", ser_txd, 1);
    check("t1_busy_stop", bus.tx_busy, 1);
    wait_clk(16);
    check("t1_busy_end", bus.tx_busy, 0);
    check("t1_txd_idle", ser_txd, 1);

    // T2: loopback 7E2, div 3, three back-to-back bytes
    loopback = 1'b1;
    baud_div = 16'd3; data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    wait_clk(2);
    bus.tx_wr = 1'b1;
    bus.tx_data = 8'h55; wait_clk(1);
    bus.tx_data = 8'h7F; wait_clk(1);
    bus.tx_data = 8'h00; wait_clk(1);
    bus.tx_wr = 1'b0;
    peak = 0;
    got3 = 1'b0;
    for (int c = 0; c < 3000 && !got3; c++) begin
      wait_clk(1);
      if (int'(bus.rx_level) > peak) peak = int'(bus.rx_level);
      if (bus.rx_level == 3'd3) got3 = 1'b1;
    end
    check("t2_level3_seen", got3, 1);
    wait_clk(300);
    check("t2_peak", peak, 3);
    check("t2_tx_done", bus.tx_busy, 0);
    loopback = 1'b0;
    check_head("t2_b0", 8'h55, 1'b0, 1'b0); pop();
    check_head("t2_b1", 8'h7F, 1'b0, 1'b0); pop();
    check_head("t2_b2", 8'h00, 1'b0, 1'b0); pop();
    check("t2_empty", bus.rx_empty, 1);

    // T3: 8O1, div 1: bad parity, then bad stop
    baud_div = 16'd1; data_bits = 2'd3; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b0;
    wait_clk(4);
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 32);
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b0, 32);
    check("t3_level", bus.rx_level, 2);
    check_head("t3_par", 8'h3C, 1'b0, 1'b1); pop();
    check_head("t3_frm", 8'h3C, 1'b1, 1'b0); pop();
    check("t3_empty", bus.rx_empty, 1);

    // T4: overflow with depth 4, 8N1 div 0
    baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0;
    wait_clk(4);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'h44, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("t4_level_full", bus.rx_level, 4);
    check("t4_ovf_before", bus.rx_ovf, 0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("t4_level_ovf", bus.rx_level, 4);
    check("t4_ovf_set", bus.rx_ovf, 1);
    check_head("t4_h0", 8'h11, 1'b0, 1'b0);
    bus.err_clr = 1'b1;
    wait_clk(1);
    bus.err_clr = 1'b0;
    check("t4_ovf_clr", bus.rx_ovf, 0);
    pop();
    check_head("t4_h1", 8'h22, 1'b0, 1'b0); pop();
    check_head("t4_h2", 8'h33, 1'b0, 1'b0); pop();
    check_head("t4_h3", 8'h44, 1'b0, 1'b0); pop();
    check("t4_empty", bus.rx_empty, 1);
    check("t4_data_empty", bus.rx_data, 0);

    // T5: 4-clk glitch rejected, then 0x81 received
    baud_div = 16'd1;
    rxd_drv = 1'b0;
    wait_clk(4);
    rxd_drv = 1'b1;
    wait_clk(60);
    check("t5_glitch_empty", bus.rx_empty, 1);
    check("t5_glitch_level", bus.rx_level, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 32);
    check("t5_level", bus.rx_level, 1);
    check_head("t5_h", 8'h81, 1'b0, 1'b0);
    pop();

    // T6: fill TX FIFO, drop extra write, reset mid-frame
    baud_div = 16'd0;
    bus.tx_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.tx_data = 8'(i);
      wait_clk(1);
      if (i == 3) check("t6_not_full", bus.tx_full, 0);
      if (i == 4) check("t6_full", bus.tx_full, 1);
      if (i == 5) check("t6_full_drop", bus.tx_full, 1);
    end
    bus.tx_wr = 1'b0;
    wait_clk(10);
    check("t6_txd_mid", ser_txd, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_txd", ser_txd, 1);
    check("t6_rst_busy", bus.tx_busy, 0);
    check("t6_rst_full", bus.tx_full, 0);
    check("t6_rst_rx_empty", bus.rx_empty, 1);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(40);
    check("t6_post_txd", ser_txd, 1);
    check("t6_post_busy", bus.tx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
